unsigned_divider_ctrl: RTL and testbench
========================================

// Module: unsigned_divider_ctrl
// PURPOSE
//  Sequential unsigned restoring divider. Initiator side of the add/sub ALU interface: drives src1/src2/funct
//  and consumes result/carry. Computes quotient and remainder of a WIDTH-bit dividend/divisor, one
//  iteration per clock. The ALU is an external, purely combinational instance; this block holds all state.
// PARAMETERS
//  WIDTH      32          operand/ALU data width
//  FUNCT_SUB  6'b001010   funct code selecting ALU subtract ({carry,result} = src1 - src2)
//  FUNCT_NOP  6'b000000   funct driven when idle (ALU returns result=0, carry=0)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request; sampled only when busy=0
//  dividend   in   WIDTH  sampled with start
//  divisor    in   WIDTH  sampled with start
//  busy       out  1      1 from the accept edge until the edge that raises valid
//  valid      out  1      one-cycle pulse: quotient/remainder/dbz are final
//  quotient   out  WIDTH  registered; holds until next accepted start
//  remainder  out  WIDTH  registered; holds until next accepted start
//  dbz        out  1      divide-by-zero flag, qualified by valid, held like quotient
//  alu_src1   out  WIDTH  to ALU src1
//  alu_src2   out  WIDTH  to ALU src2
//  alu_funct  out  6      to ALU funct
//  alu_result in   WIDTH  from ALU result
//  alu_carry  in   1      from ALU carry (borrow on subtract: 1 => src1 < src2)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, busy=0, valid=0, quotient=0, remainder=0, dbz=0, iteration count=0.
//  - States: IDLE -> CALC (start & divisor!=0) | DONE (start & divisor==0); CALC -> DONE after WIDTH
//    iterations; DONE -> IDLE unconditionally. valid=1 only in DONE. busy=1 in CALC.
//  - start while busy=1 or in DONE: ignored, no queuing.
//  - Accept edge N: R<=0, Q<=dividend, D<=divisor, cnt<=0, dbz<=0.
//  - Each CALC edge: {hi,S} = {R,Q[WIDTH-1]} (WIDTH+1 bits); alu_src1=S, alu_src2=D, alu_funct=FUNCT_SUB.
//    take = hi | ~alu_carry. take: R<=alu_result, else R<=S. Q<={Q[WIDTH-2:0],take}. cnt<=cnt+1.
//    hi=1 forces take (S+2^WIDTH > D); alu_result mod 2^WIDTH is the correct remainder.
//  - Iterations occur on edges N+1..N+WIDTH; DONE entered at edge N+WIDTH; valid high between
//    edges N+WIDTH and N+WIDTH+1. quotient/remainder update at edge N+WIDTH.
//  - Divide by zero: DONE entered at edge N; quotient=all ones, remainder=dividend, dbz=1; valid high
//    between edges N and N+1. The ALU is not used.
//  - alu_funct=FUNCT_NOP and alu_src1/alu_src2=0 outside CALC.
//  - No overflow case exists for unsigned division; Q<2^WIDTH and R<D always.
//  - Reset mid-CALC aborts; no valid pulse for the aborted operation.
// CONFIGURATION
//  DIVIDER_EARLY_EXIT_EN defined: on accept with divisor!=0 and dividend<divisor, go directly to DONE
//    at edge N with quotient=0, remainder=dividend, dbz=0. This is an internal compare, not the ALU.
//  Not defined: every nonzero-divisor operation takes the full WIDTH iterations; results are identical.
// TESTING (WIDTH=32)
//  - start 100/7 at edge N -> valid at N+32: quotient=14, remainder=2, dbz=0.
//  - 0xFFFFFFFF/0xFFFFFFFE -> quotient=1, remainder=1. 0xFFFFFFFF/0x80000001 -> quotient=1,
//    remainder=0x7FFFFFFE. Both exercise the hi=1 path.
//  - 5/0 -> valid at N (1-cycle): quotient=0xFFFFFFFF, remainder=5, dbz=1; alu_funct stays 0.
//  - 3/10 -> quotient=0, remainder=3; valid at N with DIVIDER_EARLY_EXIT_EN, at N+32 without.
//  - start pulsed during CALC with other operands -> ignored; first result unchanged; valid pulses once.
//  - rst_n low at iteration 10 -> all outputs 0 immediately. After release, 0xFFFFFFFF/1 ->
//    quotient=0xFFFFFFFF, remainder=0.

Source files
------------

// File: rtl/unsigned_divider_ctrl.sv
// Sequential unsigned restoring divider that drives an external combinational add/sub ALU.
// Optional build macro DIVIDER_EARLY_EXIT_EN finishes dividend < divisor requests on the accept edge.
module unsigned_divider_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [5:0]  FUNCT_SUB = 6'b001010,
  parameter logic [5:0]  FUNCT_NOP = 6'b000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [5:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] rem_acc, rem_acc_d;
  logic [WIDTH-1:0] quo_acc, quo_acc_d;
  logic [WIDTH-1:0] div_reg, div_reg_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             busy_d, valid_d, dbz_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic [WIDTH-1:0] src1_d, src2_d;
  logic [5:0]       funct_d;

  logic             hi, take, early;
  logic [WIDTH-1:0] rem_next, quo_next;

`ifdef DIVIDER_EARLY_EXIT_EN
  assign early = (dividend < divisor);
`else
  assign early = 1'b0;
`endif

  // alu_src1 already holds the low WIDTH bits of the shifted partial remainder; hi is its carry-out bit.
  assign hi       = rem_acc[WIDTH-1];
  assign take     = hi | ~alu_carry;
  assign rem_next = take ? alu_result : alu_src1;
  assign quo_next = {quo_acc[WIDTH-2:0], take};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem_acc   <= '0;
      quo_acc   <= '0;
      div_reg   <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      dbz       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      alu_src1  <= '0;
      alu_src2  <= '0;
      alu_funct <= FUNCT_NOP;
    end else begin
      state     <= state_d;
      rem_acc   <= rem_acc_d;
      quo_acc   <= quo_acc_d;
      div_reg   <= div_reg_d;
      cnt       <= cnt_d;
      busy      <= busy_d;
      valid     <= valid_d;
      dbz       <= dbz_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
      alu_src1  <= src1_d;
      alu_src2  <= src2_d;
      alu_funct <= funct_d;
    end
  end

  // Next state, datapath and the ALU operands for the following iteration.
  always_comb begin
    state_d     = state;
    rem_acc_d   = rem_acc;
    quo_acc_d   = quo_acc;
    div_reg_d   = div_reg;
    cnt_d       = cnt;
    dbz_d       = dbz;
    quotient_d  = quotient;
    remainder_d = remainder;
    src1_d      = '0;
    src2_d      = '0;
    funct_d     = FUNCT_NOP;

    case (state)
      IDLE: begin
        if (start) begin
          rem_acc_d = '0;
          quo_acc_d = dividend;
          div_reg_d = divisor;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else if (early) begin
            state_d     = DONE;
            quotient_d  = '0;
            remainder_d = dividend;
          end else begin
            state_d = CALC;
            src1_d  = {{(WIDTH-1){1'b0}}, dividend[WIDTH-1]};
            src2_d  = divisor;
            funct_d = FUNCT_SUB;
          end
        end
      end
      CALC: begin
        rem_acc_d = rem_next;
        quo_acc_d = quo_next;
        cnt_d     = cnt + CNT_W'(1);
        if (cnt == LAST_ITER) begin
          state_d     = DONE;
          quotient_d  = quo_next;
          remainder_d = rem_next;
        end else begin
          src1_d  = {rem_next[WIDTH-2:0], quo_next[WIDTH-1]};
          src2_d  = div_reg;
          funct_d = FUNCT_SUB;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == CALC);
    valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_unsigned_divider_ctrl.sv
// Scoreboard bench for unsigned_divider_ctrl with a behavioural subtract ALU model.
module tb_unsigned_divider_ctrl;

  localparam int unsigned WIDTH     = 32;
  localparam logic [5:0]  FUNCT_SUB = 6'b001010;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend, divisor;
  logic             busy, valid, dbz;
  logic [WIDTH-1:0] quotient, remainder;
  logic [WIDTH-1:0] alu_src1, alu_src2, alu_result;
  logic [5:0]       alu_funct;
  logic             alu_carry;
  logic [WIDTH:0]   diff;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int unsigned      acc;
    int unsigned      lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        last_exp;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  unsigned_divider_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .valid(valid), .quotient(quotient), .remainder(remainder), .dbz(dbz),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_funct(alu_funct),
    .alu_result(alu_result), .alu_carry(alu_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    diff = '0;
    if (alu_funct == FUNCT_SUB) diff = {1'b0, alu_src1} - {1'b0, alu_src2};
  end
  assign alu_result = diff[WIDTH-1:0];
  assign alu_carry  = diff[WIDTH];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Result monitor: every valid pulse pops one expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("quotient", 64'(quotient), 64'(e.q));
        check_eq("remainder", 64'(remainder), 64'(e.r));
        check_eq("dbz", 64'(dbz), 64'(e.dbz));
        check_eq("latency", 64'(cyc - e.acc), 64'(e.lat));
        if (e.dbz) check_eq("dbz_alu_funct", 64'(alu_funct), 64'd0);
      end
    end
  end

  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    e.dbz = (b == '0);
    e.q   = e.dbz ? '1 : a / b;
    e.r   = e.dbz ? a : a % b;
    e.acc = cyc + 1;
`ifdef DIVIDER_EARLY_EXIT_EN
    e.lat = (e.dbz || a < b) ? 0 : WIDTH;
`else
    e.lat = e.dbz ? 0 : WIDTH;
`endif
    sb.push_back(e);
    last_exp = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned base, input string tag);
    int unsigned n = 0;
    while (done_cnt == base && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == base) check_eq({tag, "_timeout"}, 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int unsigned base;
    base = done_cnt;
    drive(a, b);
    check_eq("busy_after_accept", 64'(busy), 64'(last_exp.lat != 0));
    wait_done(base, "run");
    @(negedge clk);
    check_eq("quotient_hold", 64'(quotient), 64'(last_exp.q));
    check_eq("remainder_hold", 64'(remainder), 64'(last_exp.r));
  endtask

  initial begin
    int unsigned base;
    start = 1'b0; dividend = '0; divisor = '0; rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_quotient", 64'(quotient), 64'd0);
    check_eq("rst_remainder", 64'(remainder), 64'd0);
    check_eq("rst_alu_funct", 64'(alu_funct), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run(32'd100, 32'd7);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run(32'hFFFF_FFFF, 32'h8000_0001);
    run(32'd5, 32'd0);
    run(32'd3, 32'd10);
    run(32'd0, 32'd9);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] a, b;
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 255)) : 32'($urandom);
      run(a, b);
    end

    // start pulses during CALC must be dropped
    base = done_cnt;
    drive(32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(base, "ignored_start");
    repeat (3) @(negedge clk);
    check_eq("single_valid", 64'(done_cnt - base), 64'd1);
    check_eq("queue_empty", 64'(sb.size()), 64'd0);

    // reset in the middle of an operation
    base = done_cnt;
    drive(32'hDEAD_BEEF, 32'd3);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_valid", 64'(valid), 64'd0);
    check_eq("abort_quotient", 64'(quotient), 64'd0);
    check_eq("abort_remainder", 64'(remainder), 64'd0);
    check_eq("abort_dbz", 64'(dbz), 64'd0);
    check_eq("abort_alu_src1", 64'(alu_src1), 64'd0);
    check_eq("abort_alu_funct", 64'(alu_funct), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("abort_no_valid", 64'(done_cnt - base), 64'd0);
    run(32'hFFFF_FFFF, 32'd1);

    check_eq("final_queue_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
